// File: rtl/pdm_record_ctrl.sv
// Record/playback controller for the PDM microphone path.
// Captures the microphone amplitude stream into a single-port sample RAM and
// replays it over a valid/ready stream. Record and playback are mutually
// exclusive; this block is the only master of the RAM port.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start_rec/start_play/stop   one-cycle command pulses
//   amplitude, amplitude_valid  microphone sample stream
//   mic_en              microphone front-end enable (high while recording)
//   ram_we/ram_re/ram_addr/ram_wdata/ram_rdata  sample RAM port (1-cycle read latency)
//   play_data, play_valid, play_ready           playback stream
//   rec_len             number of stored samples (0..DEPTH)
//   full                last recording ended on capacity
//   busy                controller not idle
//   done                pulse on normal end of record or playback
module pdm_record_ctrl #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned SAMPLE_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_rec,
  input  logic                start_play,
  input  logic                stop,
  input  logic [SAMPLE_W-1:0] amplitude,
  input  logic                amplitude_valid,
  output logic                mic_en,
  output logic                ram_we,
  output logic                ram_re,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [SAMPLE_W-1:0] ram_wdata,
  input  logic [SAMPLE_W-1:0] ram_rdata,
  output logic [SAMPLE_W-1:0] play_data,
  output logic                play_valid,
  input  logic                play_ready,
  output logic [ADDR_W:0]     rec_len,
  output logic                full,
  output logic                busy,
  output logic                done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]  FULL_LEN  = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECORD,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              last_sample_c;

  // Current playback sample is the final stored one.
  assign last_sample_c = (LEN_W'(rd_ptr) + LEN_W'(1)) == rec_len;

  // Controller state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mic_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      play_data  <= '0;
      play_valid <= 1'b0;
      rec_len    <= '0;
      full       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // RAM strobes and done are single-cycle pulses.
      ram_we <= 1'b0;
      ram_re <= 1'b0;
      done   <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start_rec) begin
            state   <= ST_RECORD;
            wr_ptr  <= '0;
            rec_len <= '0;
            full    <= 1'b0;
            mic_en  <= 1'b1;
            busy    <= 1'b1;
          end else if (start_play && (rec_len != '0)) begin
            // Issue the first read on entry so FETCH is the read cycle.
            state    <= ST_FETCH;
            rd_ptr   <= '0;
            ram_re   <= 1'b1;
            ram_addr <= '0;
            busy     <= 1'b1;
          end
        end

        ST_RECORD: begin
          if (amplitude_valid) begin
            ram_we    <= 1'b1;
            ram_addr  <= wr_ptr;
            ram_wdata <= amplitude;
            wr_ptr    <= wr_ptr + ADDR_W'(1);
          end
          // Capacity end takes priority over a coincident stop.
          if (amplitude_valid && (wr_ptr == LAST_ADDR)) begin
            state   <= ST_IDLE;
            rec_len <= FULL_LEN;
            full    <= 1'b1;
            done    <= 1'b1;
            mic_en  <= 1'b0;
            busy    <= 1'b0;
          end else if (stop) begin
            // A sample strobed alongside stop is still counted.
            state   <= ST_IDLE;
            rec_len <= LEN_W'(wr_ptr) + LEN_W'(amplitude_valid);
            done    <= 1'b1;
            mic_en  <= 1'b0;
            busy    <= 1'b0;
          end
        end

        ST_FETCH: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            play_data  <= ram_rdata;
            play_valid <= 1'b1;
            state      <= ST_PRESENT;
          end
        end

        ST_PRESENT: begin
          if (stop) begin
            state      <= ST_IDLE;
            play_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (play_ready) begin
            play_valid <= 1'b0;
            if (last_sample_c) begin
              state <= ST_IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              rd_ptr   <= rd_ptr + ADDR_W'(1);
              ram_re   <= 1'b1;
              ram_addr <= rd_ptr + ADDR_W'(1);
              state    <= ST_FETCH;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_record_ctrl.sv
// Self-checking bench for pdm_record_ctrl with a 16-entry sample RAM model.
module tb_pdm_record_ctrl;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned SAMPLE_W = 7;
  localparam int          DEPTH    = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_rec, start_play, stop;
  logic [SAMPLE_W-1:0] amplitude;
  logic                amplitude_valid;
  logic                mic_en, ram_we, ram_re;
  logic [ADDR_W-1:0]   ram_addr;
  logic [SAMPLE_W-1:0] ram_wdata, ram_rdata, play_data;
  logic                play_valid, play_ready;
  logic [ADDR_W:0]     rec_len;
  logic                full, busy, done;

  pdm_record_ctrl #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) dut (
    .clk(clk), .rst(rst),
    .start_rec(start_rec), .start_play(start_play), .stop(stop),
    .amplitude(amplitude), .amplitude_valid(amplitude_valid),
    .mic_en(mic_en), .ram_we(ram_we), .ram_re(ram_re),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .play_data(play_data), .play_valid(play_valid), .play_ready(play_ready),
    .rec_len(rec_len), .full(full), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency.
  logic [SAMPLE_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  typedef struct packed {
    logic [ADDR_W-1:0]   a;
    logic [SAMPLE_W-1:0] d;
  } wr_t;

  typedef struct {
    logic                srec, stp, av;
    logic [SAMPLE_W-1:0] amp;
    logic                e_mic, e_we;
    logic [ADDR_W-1:0]   e_addr;
    logic [SAMPLE_W-1:0] e_wd;
    logic                e_busy, e_done;
    logic [ADDR_W:0]     e_len;
    logic                e_full;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  wr_t wq[$];
  logic [SAMPLE_W-1:0] exp_mem [DEPTH];
  int exp_len = 0;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; observe outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ram_we) wq.push_back('{a: ram_addr, d: ram_wdata});
    if (done) done_cnt++;
    chk("we_re_exclusive", 32'(ram_we & ram_re), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mic_en"}, 32'(mic_en), 32'(0));
    chk({tag, "_ram_we"}, 32'(ram_we), 32'(0));
    chk({tag, "_ram_re"}, 32'(ram_re), 32'(0));
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(0));
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'(0));
    chk({tag, "_play_data"}, 32'(play_data), 32'(0));
    chk({tag, "_play_valid"}, 32'(play_valid), 32'(0));
    chk({tag, "_rec_len"}, 32'(rec_len), 32'(0));
    chk({tag, "_full"}, 32'(full), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
  endtask

  // Record n random samples; model: first min(n,DEPTH) land at 0.. in order.
  task automatic record(input int n, input bit stop_last, input bit rnd);
    logic [SAMPLE_W-1:0] v;
    int nw;
    wq.delete();
    done_cnt = 0;
    start_rec = 1'b1;
    tick();
    start_rec = 1'b0;
    chk("rec_mic_on", 32'(mic_en), 32'(1));
    chk("rec_busy", 32'(busy), 32'(1));
    chk("rec_len_cleared", 32'(rec_len), 32'(0));
    chk("rec_full_cleared", 32'(full), 32'(0));
    for (int i = 0; i < n; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) tick();
      v = SAMPLE_W'($urandom);
      if (i < DEPTH) exp_mem[4'(i)] = v;
      amplitude = v;
      amplitude_valid = 1'b1;
      stop = stop_last && (i == n - 1);
      tick();
      amplitude_valid = 1'b0;
      stop = 1'b0;
    end
    if (!stop_last) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    tick();
    nw = (n < DEPTH) ? n : DEPTH;
    chk("rec_len_final", 32'(rec_len), 32'(nw));
    chk("rec_full_final", 32'(full), 32'(n >= DEPTH));
    chk("rec_mic_off", 32'(mic_en), 32'(0));
    chk("rec_idle", 32'(busy), 32'(0));
    chk("rec_done_pulses", 32'(done_cnt), 32'(1));
    chk("rec_write_count", 32'(wq.size()), 32'(nw));
    for (int k = 0; k < wq.size() && k < nw; k++) begin
      chk("rec_write_addr", 32'(wq[k].a), 32'(k));
      chk("rec_write_data", 32'(wq[k].d), 32'(exp_mem[4'(k)]));
    end
    exp_len = nw;
  endtask

  // Play back n samples; one sample stalled stall_len cycles, others random if rnd.
  task automatic play(input int n, input int stall_idx, input int stall_len, input bit rnd);
    int last;
    int waitc;
    int st;
    start_play = 1'b1;
    last = cyc;
    tick();
    start_play = 1'b0;
    chk("play_entry_re", 32'(ram_re), 32'(1));
    chk("play_entry_addr", 32'(ram_addr), 32'(0));
    for (int i = 0; i < n; i++) begin
      waitc = 0;
      play_ready = !rnd && (stall_idx < 0);
      while (!play_valid && waitc < 8) begin
        tick();
        waitc++;
      end
      chk("play_valid_seen", 32'(play_valid), 32'(1));
      chk("play_valid_latency", 32'(cyc - last), 32'(3));
      chk("play_data", 32'(play_data), 32'(exp_mem[4'(i)]));
      st = (i == stall_idx) ? stall_len : (rnd ? int'($urandom_range(0, 3)) : 0);
      for (int k = 0; k < st; k++) begin
        play_ready = 1'b0;
        start_rec = (k == 0);
        amplitude_valid = rnd;
        amplitude = SAMPLE_W'($urandom);
        tick();
        start_rec = 1'b0;
        amplitude_valid = 1'b0;
        chk("stall_valid_held", 32'(play_valid), 32'(1));
        chk("stall_data_held", 32'(play_data), 32'(exp_mem[4'(i)]));
        chk("stall_no_read", 32'(ram_re), 32'(0));
        chk("stall_no_write", 32'(ram_we), 32'(0));
        chk("stall_busy", 32'(busy), 32'(1));
      end
      play_ready = 1'b1;
      last = cyc;
      tick();
      play_ready = 1'b0;
      chk("hs_valid_drop", 32'(play_valid), 32'(0));
      if (i == n - 1) begin
        chk("play_done", 32'(done), 32'(1));
        chk("play_end_idle", 32'(busy), 32'(0));
      end else begin
        chk("play_no_early_done", 32'(done), 32'(0));
        chk("play_next_re", 32'(ram_re), 32'(1));
        chk("play_next_addr", 32'(ram_addr), 32'(i + 1));
      end
    end
    tick();
    chk("play_done_one_cycle", 32'(done), 32'(0));
    chk("play_rec_len_kept", 32'(rec_len), 32'(exp_len));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    rst = 1'b1;
    start_rec = 1'b0;
    start_play = 1'b0;
    stop = 1'b0;
    amplitude = '0;
    amplitude_valid = 1'b0;
    play_ready = 1'b0;

    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // srec stp av amp | mic we addr wd busy done len full
    tbl[0] = '{1'b0, 1'b1, 1'b1, 7'd9, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 5'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, 1'b0, 5'd0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 7'd1, 1'b1, 1'b1, 4'd0, 7'd1, 1'b1, 1'b0, 5'd0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 7'd2, 1'b1, 1'b1, 4'd1, 7'd2, 1'b1, 1'b0, 5'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, 1'b0, 5'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 7'd3, 1'b1, 1'b1, 4'd2, 7'd3, 1'b1, 1'b0, 5'd0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 7'd4, 1'b1, 1'b1, 4'd3, 7'd4, 1'b1, 1'b0, 5'd0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 7'd5, 1'b0, 1'b1, 4'd4, 7'd5, 1'b0, 1'b1, 5'd5, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 5'd5, 1'b0};
    for (int i = 0; i < 9; i++) begin
      start_rec = tbl[i].srec;
      stop = tbl[i].stp;
      amplitude_valid = tbl[i].av;
      amplitude = tbl[i].amp;
      tick();
      chk("tbl_mic_en", 32'(mic_en), 32'(tbl[i].e_mic));
      chk("tbl_ram_we", 32'(ram_we), 32'(tbl[i].e_we));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
      chk("tbl_done", 32'(done), 32'(tbl[i].e_done));
      chk("tbl_rec_len", 32'(rec_len), 32'(tbl[i].e_len));
      chk("tbl_full", 32'(full), 32'(tbl[i].e_full));
      if (tbl[i].e_we) begin
        chk("tbl_ram_addr", 32'(ram_addr), 32'(tbl[i].e_addr));
        chk("tbl_ram_wdata", 32'(ram_wdata), 32'(tbl[i].e_wd));
      end
    end
    start_rec = 1'b0;
    stop = 1'b0;
    amplitude_valid = 1'b0;
    for (int i = 0; i < 5; i++) exp_mem[4'(i)] = 7'(i + 1);
    exp_len = 5;

    // Playback with ready tied high, then with sample 2 stalled 10 cycles.
    play(5, -1, 0, 1'b0);
    play(5, 1, 10, 1'b0);

    // Abort playback while a sample is presented.
    done_cnt = 0;
    start_play = 1'b1;
    tick();
    start_play = 1'b0;
    waitc = 0;
    while (!play_valid && waitc < 8) begin
      tick();
      waitc++;
    end
    chk("abort_valid_seen", 32'(play_valid), 32'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_valid_drop", 32'(play_valid), 32'(0));
    chk("abort_idle", 32'(busy), 32'(0));
    chk("abort_rec_len", 32'(rec_len), 32'(5));
    tick();
    chk("abort_no_done", 32'(done_cnt), 32'(0));
    chk("abort_no_read", 32'(ram_re), 32'(0));

    // Reset in the middle of a recording discards it.
    start_rec = 1'b1;
    tick();
    start_rec = 1'b0;
    amplitude = 7'd33;
    amplitude_valid = 1'b1;
    tick();
    tick();
    amplitude_valid = 1'b0;
    chk("prerst_mic", 32'(mic_en), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    tick();
    chk("postrst_len", 32'(rec_len), 32'(0));
    chk("postrst_idle", 32'(busy), 32'(0));

    // start_play with nothing recorded is ignored.
    start_play = 1'b1;
    tick();
    start_play = 1'b0;
    chk("empty_play_busy", 32'(busy), 32'(0));
    chk("empty_play_no_read", 32'(ram_re), 32'(0));
    tick();
    chk("empty_play_no_valid", 32'(play_valid), 32'(0));

    // start_rec beats a coincident start_play.
    start_rec = 1'b1;
    start_play = 1'b1;
    tick();
    start_rec = 1'b0;
    start_play = 1'b0;
    chk("both_mic", 32'(mic_en), 32'(1));
    chk("both_busy", 32'(busy), 32'(1));
    chk("both_no_read", 32'(ram_re), 32'(0));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("empty_stop_len", 32'(rec_len), 32'(0));
    chk("empty_stop_done", 32'(done), 32'(1));
    exp_len = 0;

    // Capacity: 20 strobes, only 16 stored; play them all back.
    record(20, 1'b0, 1'b0);
    play(exp_len, -1, 0, 1'b1);

    // Randomized record/playback rounds.
    for (int r = 0; r < 8; r++) begin
      record(int'($urandom_range(1, 20)), 1'(($urandom & 1)), 1'b1);
      play(exp_len, int'($urandom_range(0, 15)), 4, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdm_record_ctrl.md
# pdm_record_ctrl

Record/playback controller for the PDM microphone path. It gates the microphone front end and captures its 7-bit amplitude stream into a single-port sample RAM. On request it replays the stored samples to a downstream consumer (PWM/audio out) over a valid/ready stream. It owns the RAM port exclusively and sequences record and playback so they never overlap.

## Interface
Parameters:
- ADDR_W, 17, RAM address width; capacity DEPTH = 2**ADDR_W samples
- SAMPLE_W, 7, amplitude width

Ports:
- clk  in  1  system clock (100 MHz); single clock domain
- rst  in  1  synchronous, active-high reset
- start_rec  in  1  one-cycle pulse: begin recording
- start_play  in  1  one-cycle pulse: begin playback
- stop  in  1  one-cycle pulse: end current record/playback
- amplitude  in  SAMPLE_W  sample from microphone front end
- amplitude_valid  in  1  one-cycle strobe qualifying amplitude
- mic_en  out  1  enable for microphone front end; high only while recording
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe; ram_rdata valid exactly 1 cycle later
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  SAMPLE_W  RAM write data
- ram_rdata  in  SAMPLE_W  RAM read data
- play_data  out  SAMPLE_W  playback sample
- play_valid  out  1  play_data valid
- play_ready  in  1  consumer accepts play_data when play_valid && play_ready
- rec_len  out  ADDR_W+1  number of valid stored samples (0..DEPTH)
- full  out  1  sticky: last recording stopped on capacity
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on normal end of record or playback

## Operation
- States: IDLE, RECORD, FETCH, WAIT, PRESENT.
- IDLE: start_rec -> RECORD (wr_ptr=0, rec_len=0, full=0). Otherwise start_play with rec_len!=0 -> FETCH (rd_ptr=0). start_rec wins if both are asserted. start_play with rec_len==0 is ignored. stop is ignored.
- RECORD: mic_en=1. Each amplitude_valid writes amplitude to wr_ptr, then wr_ptr++.
  - stop -> IDLE, rec_len=wr_ptr (count includes a sample strobed in the same cycle), done pulse.
  - Write to address DEPTH-1 -> IDLE, rec_len=DEPTH, full=1, done pulse.
- FETCH: ram_re=1, ram_addr=rd_ptr -> WAIT.
- WAIT: play_data<=ram_rdata, play_valid<=1 -> PRESENT.
- PRESENT: hold play_data/play_valid until play_ready.
  - On handshake: play_valid<=0. If rd_ptr==rec_len-1 -> IDLE with done pulse; else rd_ptr++ and -> FETCH.
- stop in FETCH/WAIT/PRESENT -> IDLE next cycle. play_valid drops, no done, rec_len unchanged.
- start_rec/start_play outside IDLE are ignored. amplitude_valid outside RECORD is ignored. ram_we and ram_re are never both high.
- Pointers are unsigned ADDR_W wide. rec_len is ADDR_W+1 so DEPTH is representable. No wrap: recording never overwrites address 0.

## Timing
- Reset values: mic_en=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, play_data=0, play_valid=0, rec_len=0, full=0, busy=0, done=0. State=IDLE. Reset mid-operation discards the recording (rec_len=0).
- All outputs are registered.
- start_rec at cycle t: busy and mic_en high at t+1.
- amplitude_valid at t: ram_we/ram_addr/ram_wdata at t+1, one cycle wide.
- stop at t: state=IDLE, mic_en=0, rec_len and done updated at t+1. A ram_we caused by a strobe at t still issues at t+1.
- Playback entry (start_play at t): ram_re at t+1, play_valid at t+3.
- Handshake at t: next ram_re at t+1, next play_valid at t+3. Minimum 3 cycles per sample, far faster than the microphone rate.
- done is asserted the cycle after the final write or final handshake.

## Test plan
- ADDR_W=4. start_rec, 5 amplitude_valid strobes (values 1..5), stop -> RAM addr 0..4 = 1..5, rec_len=5, full=0, done one pulse, mic_en low the cycle after stop.
- ADDR_W=4. Record 20 strobes without stop -> 16 writes, returns to IDLE after addr 15, rec_len=16, full=1; strobes 17..20 produce no ram_we.
- After the 5-sample recording, start_play with play_ready tied high -> play_data sequence 1,2,3,4,5. Each play_valid starts 3 cycles after the previous handshake. done follows the 5th handshake.
- Playback with play_ready low for 10 cycles on sample 2 -> play_data held at 2 and play_valid held high. No ram_re issued until the handshake.
- start_play with rec_len=0 -> stays IDLE, busy=0. start_rec and start_play in the same cycle -> RECORD entered.
- stop during PRESENT, then rst during RECORD -> first: IDLE, play_valid=0, rec_len unchanged, no done. Second: all outputs at reset values, rec_len=0.
